// File: rtl/bcd_scan_display.sv
// Scans a 4-digit packed BCD value onto a shared 7-segment bus with a one-hot digit select.
// Define BCD_SCAN_LZB_EN to blank leading zeros (digit 0 is never blanked).
module bcd_scan_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] q,
  output logic [3:0]  dig_sel,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] div;
  logic [1:0]  idx;
  logic [15:0] snap;
  logic        primed;

  logic        div_wrap;
  logic        frame_wrap;
  logic        blank;
  logic [3:0]  nibble;
  logic [6:0]  seg_next;
  logic [3:0]  dig_sel_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;  // "E" for any non-BCD nibble
    endcase
    return s;
  endfunction

  assign div_wrap   = (div == DIV_MAX);
  assign frame_wrap = div_wrap && (idx == 2'd3);
  assign nibble     = snap[4*idx +: 4];

`ifdef BCD_SCAN_LZB_EN
  // A digit is blank only when it and every more-significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    unique case (idx)
      2'd1:    blank = (snap[15:4]  == 12'h000);
      2'd2:    blank = (snap[15:8]  == 8'h00);
      2'd3:    blank = (snap[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    seg_next     = 7'h00;
    dig_sel_next = 4'b0001 << idx;
    if (!blank) seg_next = decode(nibble);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div        <= '0;
      idx        <= '0;
      snap       <= '0;
      primed     <= 1'b0;
      dig_sel    <= '0;
      seg        <= '0;
      frame_done <= 1'b0;
    end else begin
      div        <= div_wrap ? '0 : div + 16'd1;
      if (div_wrap) idx <= idx + 2'd1;
      // Snapshot on the first edge out of reset and at every frame wrap only.
      if (!primed || frame_wrap) snap <= q;
      primed     <= 1'b1;
      frame_done <= frame_wrap;
      dig_sel    <= dig_sel_next;
      seg        <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display with SCAN_DIV = 2; expectations follow BCD_SCAN_LZB_EN.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] q = '0;
  logic [3:0]  dig_sel;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

`ifdef BCD_SCAN_LZB_EN
  localparam logic [6:0] Z = 7'h00;
`else
  localparam logic [6:0] Z = 7'h3F;
`endif

  bcd_scan_display #(.SCAN_DIV(2)) dut (
    .clk(clk),
    .reset(reset),
    .q(q),
    .dig_sel(dig_sel),
    .seg(seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic step_to(input int n);
    while (edge_cnt < n) step();
  endtask

  task automatic apply_reset(input logic [15:0] val);
    reset = 1'b1;
    q = val;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_cnt = 0;
  endtask

  typedef struct {
    logic [15:0]     q;
    logic [3:0][6:0] segs;  // expected seg for digits 0..3
  } vec_t;

  vec_t vecs[8];
  logic [11:0] seq1234[1:17];

  initial begin
    vecs[0] = '{16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'h0042, {Z,     Z,     7'h66, 7'h5B}};
    vecs[2] = '{16'h0000, {Z,     Z,     Z,     7'h3F}};
    vecs[3] = '{16'h00A0, {Z,     Z,     7'h79, 7'h3F}};
    vecs[4] = '{16'h9876, {7'h6F, 7'h7F, 7'h07, 7'h7D}};
    vecs[5] = '{16'h0005, {Z,     Z,     Z,     7'h6D}};
    vecs[6] = '{16'hF0F0, {7'h79, 7'h3F, 7'h79, 7'h3F}};
    vecs[7] = '{16'h0300, {Z,     7'h4F, 7'h3F, 7'h3F}};

    seq1234[1]  = {4'h1, 7'h3F, 1'b0};
    seq1234[2]  = {4'h1, 7'h66, 1'b0};
    seq1234[3]  = {4'h2, 7'h4F, 1'b0};
    seq1234[4]  = {4'h2, 7'h4F, 1'b0};
    seq1234[5]  = {4'h4, 7'h5B, 1'b0};
    seq1234[6]  = {4'h4, 7'h5B, 1'b0};
    seq1234[7]  = {4'h8, 7'h06, 1'b0};
    seq1234[8]  = {4'h8, 7'h06, 1'b1};
    seq1234[9]  = {4'h1, 7'h66, 1'b0};
    seq1234[10] = {4'h1, 7'h66, 1'b0};
    seq1234[11] = {4'h2, 7'h4F, 1'b0};
    seq1234[12] = {4'h2, 7'h4F, 1'b0};
    seq1234[13] = {4'h4, 7'h5B, 1'b0};
    seq1234[14] = {4'h4, 7'h5B, 1'b0};
    seq1234[15] = {4'h8, 7'h06, 1'b0};
    seq1234[16] = {4'h8, 7'h06, 1'b1};
    seq1234[17] = {4'h1, 7'h66, 1'b0};

    // Reset state
    apply_reset(16'h1234);
    reset = 1'b1;
    #1;
    check("reset_dig_sel", 16'(dig_sel), 16'h0);
    check("reset_seg", 16'(seg), 16'h0);
    check("reset_frame_done", 16'(frame_done), 16'h0);

    // Full cycle-by-cycle run of 1234 including frame_done cadence
    apply_reset(16'h1234);
    for (int k = 1; k <= 17; k++) begin
      step();
      check($sformatf("seq1234_dig_e%0d", k), 16'(dig_sel), 16'(seq1234[k][11:8]));
      check($sformatf("seq1234_seg_e%0d", k), 16'(seg), 16'(seq1234[k][7:1]));
      check($sformatf("seq1234_fd_e%0d", k), 16'(frame_done), 16'(seq1234[k][0]));
    end

    // Table-driven decode/blanking: digit i visible after edge 2*(i+1)
    for (int v = 0; v < 8; v++) begin
      apply_reset(vecs[v].q);
      for (int d = 0; d < 4; d++) begin
        step_to(2 * (d + 1));
        check($sformatf("vec%0d_q%h_dig%0d_sel", v, vecs[v].q, d), 16'(dig_sel), 16'(4'b0001 << d));
        check($sformatf("vec%0d_q%h_dig%0d_seg", v, vecs[v].q, d), 16'(seg), 16'(vecs[v].segs[d]));
      end
    end

    // Snapshot holds when q changes mid-frame
    apply_reset(16'h1111);
    step_to(3);
    q = 16'h2222;
    for (int k = 4; k <= 8; k++) begin
      step_to(k);
      check($sformatf("snap_hold_seg_e%0d", k), 16'(seg), 16'h06);
    end
    check("snap_hold_fd_e8", 16'(frame_done), 16'h1);
    step_to(9);
    check("snap_new_seg_e9", 16'(seg), 16'h5B);
    check("snap_new_fd_e9", 16'(frame_done), 16'h0);
    step_to(10);
    check("snap_new_seg_e10", 16'(seg), 16'h5B);

    // Asynchronous reset mid-frame, then fresh restart
    apply_reset(16'h1234);
    step_to(5);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_dig_sel", 16'(dig_sel), 16'h0);
    check("async_rst_seg", 16'(seg), 16'h0);
    check("async_rst_fd", 16'(frame_done), 16'h0);
    q = 16'h0005;
    @(negedge clk);
    @(negedge clk);
    check("held_rst_seg", 16'(seg), 16'h0);
    reset = 1'b0;
    edge_cnt = 0;
    step();
    check("restart_e1_dig", 16'(dig_sel), 16'h1);
    check("restart_e1_seg", 16'(seg), 16'h3F);
    step();
    check("restart_e2_seg", 16'(seg), 16'h6D);
    step();
    check("restart_e3_dig", 16'(dig_sel), 16'h2);
    check("restart_e3_seg", 16'(seg), 16'(Z));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
